// File: rtl/cd_rx_ram_n_if.sv
// CDBUS receive frame RAM bus: byte write side from cd_rx_bytes,
// word read side towards cd_csr.
interface cd_rx_ram_n_if #(
    parameter int PAGES = 4,
    parameter int CW    = $clog2(PAGES)
);
    logic [7:0]  wr_byte;
    logic [7:0]  wr_addr;
    logic        wr_en;
    logic [7:0]  wr_len;
    logic        wr_err;
    logic        switch;
    logic        switch_fail;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic [31:0] rd_word;
    logic [7:0]  rd_len;
    logic        rd_err;
    logic        rd_done;
    logic        rd_done_all;
    logic        unread;
    logic [CW:0] pending_cnt;

    modport master (
        output wr_byte, wr_addr, wr_en, wr_len, wr_err,
        output switch, rd_en, rd_addr, rd_done, rd_done_all,
        input  switch_fail, rd_word, rd_len, rd_err,
        input  unread, pending_cnt
    );

    modport slave (
        input  wr_byte, wr_addr, wr_en, wr_len, wr_err,
        input  switch, rd_en, rd_addr, rd_done, rd_done_all,
        output switch_fail, rd_word, rd_len, rd_err,
        output unread, pending_cnt
    );
endinterface

// File: rtl/cd_rx_ram_n.sv
// CDBUS receive frame RAM: circular queue of PAGES 256-byte pages,
// holding up to PAGES-1 committed frames plus one page being filled.
module cd_rx_ram_n #(
    parameter int PAGES = 4,
    parameter int CW    = $clog2(PAGES)
) (
    input logic          clk,
    input logic          reset_n,
    cd_rx_ram_n_if.slave bus
);
    localparam int          WORDS   = PAGES * 64;
    localparam int          AW      = CW + 6;
    localparam logic [CW:0] CNT_MAX = (CW + 1)'(PAGES - 1);

    logic [CW-1:0] wp;
    logic [CW-1:0] rp;
    logic [CW:0]   cnt;
    logic          fail_q;
    logic [7:0]    meta_len [PAGES];
    logic          meta_err [PAGES];

    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          release_ok;
    logic          full_after;
    logic          commit;
    logic          drop;
    logic [CW:0]   cnt_nxt;

    assign wr_idx = {wp, bus.wr_addr[7:2]};
    assign rd_idx = {rp, bus.rd_addr};

    // Release is evaluated before the switch so a full queue can still accept.
    always_comb begin
        release_ok = bus.rd_done && (cnt != '0);
        full_after = (cnt - (CW + 1)'(release_ok)) == CNT_MAX;
        commit     = bus.switch && !bus.rd_done_all && !full_after;
        drop       = bus.switch && !bus.rd_done_all && full_after;
        cnt_nxt    = cnt + (CW + 1)'(commit) - (CW + 1)'(release_ok);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp     <= '0;
            rp     <= '0;
            cnt    <= '0;
            fail_q <= 1'b0;
        end else begin
            fail_q <= drop;
            if (bus.rd_done_all) begin
                rp  <= wp;
                cnt <= '0;
            end else begin
                if (release_ok) rp <= rp + CW'(1);
                if (commit)     wp <= wp + CW'(1);
                cnt <= cnt_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PAGES; i++) begin
                meta_len[i] <= '0;
                meta_err[i] <= 1'b0;
            end
        end else if (commit) begin
            meta_len[wp] <= bus.wr_len;
            meta_err[wp] <= bus.wr_err;
        end
    end

    logic [7:0] lane_q [4];

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [WORDS];

        always_ff @(posedge clk) begin
            if (bus.wr_en && (bus.wr_addr[1:0] == 2'(l)))
                mem[wr_idx] <= bus.wr_byte;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                lane_q[l] <= '0;
            else if (bus.rd_en)
                lane_q[l] <= mem[rd_idx];
        end
    end

    assign bus.rd_word     = {lane_q[3], lane_q[2], lane_q[1], lane_q[0]};
    assign bus.rd_len      = (cnt != '0) ? meta_len[rp] : 8'd0;
    assign bus.rd_err      = (cnt != '0) ? meta_err[rp] : 1'b0;
    assign bus.switch_fail = fail_q;
    assign bus.unread      = (cnt != '0);
    assign bus.pending_cnt = cnt;
endmodule

// File: doc/cd_rx_ram_n.md
# cd_rx_ram_n

Parametrised successor to the two-page CDBUS receive frame RAM. It holds up to PAGES-1 complete received frames plus one page being filled, in a circular page queue. Bytes come in from `cd_rx_bytes`; 32-bit words go out to `cd_csr`. This lets firmware with slow interrupt service absorb bursts of back-to-back frames without `switch_fail` losses.

## Interface
- PAGES, 4, number of 256-byte pages; power of 2, 2..16; at most PAGES-1 frames are stored.
- CW, $clog2(PAGES), width of the page pointers.
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- wr_byte  input  8  received byte.
- wr_addr  input  8  byte offset in the current write page.
- wr_en  input  1  write strobe for wr_byte.
- wr_len  input  8  frame length; sampled on switch.
- wr_err  input  1  frame error flag; sampled on switch.
- switch  input  1  one-cycle pulse that commits the current write page as a frame.
- switch_fail  output  1  one-cycle pulse: queue full, frame dropped.
- rd_en  input  1  read enable (chip select); gates RAM read power.
- rd_addr  input  6  word offset in the head page.
- rd_word  output  32  registered read data, little-endian (byte 0 in bits 7:0).
- rd_len  output  8  length of the head frame.
- rd_err  output  1  error flag of the head frame.
- rd_done  input  1  one-cycle pulse that releases the head frame.
- rd_done_all  input  1  one-cycle pulse that releases all stored frames (abort/clean).
- unread  output  1  at least one stored frame (cnt != 0).
- pending_cnt  output  CW+1  number of stored frames.

## Operation
- **State.** The block holds write pointer wp, read pointer rp, and count cnt, all CW bits wide except cnt (CW+1). Pointers wrap modulo PAGES naturally.
- **Memory.**
  - Four 8-bit byte lanes, each PAGES*64 deep.
  - Word index is {page, addr[7:2]}; lane is addr[1:0].
  - Per-page metadata: len[7:0] and err.
- **Write.** On wr_en, wr_byte goes to lane wr_addr[1:0] of word {wp, wr_addr[7:2]}. A write coincident with switch lands in the old wp.
- **Commit (switch, queue not full after this cycle's release).**
  - meta[wp] <= {wr_err, wr_len}.
  - wp <= wp+1 and cnt increments.
- **Drop (switch while cnt == PAGES-1 and no coincident rd_done).**
  - switch_fail pulses on the next cycle.
  - wp, cnt and metadata are unchanged.
  - The next frame overwrites the same page.
- **rd_done.**
  - If cnt > 0: rp <= rp+1 and cnt decrements.
  - At cnt == 0 it is ignored.
- **Same-cycle rd_done + switch.**
  - The release is evaluated first, so a full queue accepts the frame.
  - Net effect: cnt unchanged, both pointers advance, no switch_fail.
- **rd_done_all.**
  - rp <= wp and cnt <= 0.
  - A coincident switch or rd_done is discarded, with no switch_fail.
  - It has the highest priority.
- **Read.** rd_len/rd_err = meta[rp] when cnt != 0, else 0. They are combinational from registered state.
- **Outputs.** unread = (cnt != 0); pending_cnt = cnt.

## Timing
- **Reset.** Asynchronous assertion clears:
  - wp = rp = cnt = 0;
  - rd_word = 0, switch_fail = 0, unread = 0, pending_cnt = 0;
  - metadata len = 0, err = 0.
  - RAM contents are not cleared.
  - Reset mid-frame or mid-read simply discards all state.
- **Write latency.** A byte written in cycle N is readable through rd_word from cycle N+1 onward, once its page is the head.
- **Read latency.** rd_word updates one cycle after rd_en is sampled high, from {rp, rd_addr}. With rd_en low, rd_word holds its value.
- **Commit latency.** For a switch in cycle N, unread, pending_cnt, rd_len and rd_err reflect the new frame from cycle N+1.
- **rd_done latency.** rd_done in cycle N exposes the next head frame's rd_len/rd_err at N+1. rd_word changes only on the next rd_en read.
- **Pulse inputs.** switch, rd_done and rd_done_all are single-cycle pulses. If held high, each high cycle counts as a separate event.
- **Boundaries.**
  - wp/rp wrap from PAGES-1 to 0.
  - cnt saturates at PAGES-1 via the drop rule.
  - cnt never underflows.

## Test plan
- **Basic fill and drain (PAGES=4).**
  - Stimulus: write bytes 0x11,0x22,0x33,0x44 to addr 0..3, then switch with wr_len=4, wr_err=0.
  - Required: next cycle unread=1, pending_cnt=1, rd_len=4. With rd_en=1 and rd_addr=0, rd_word=0x44332211 one cycle later.
  - Stimulus: rd_done. Required: unread=0.
- **Overflow.**
  - Stimulus: 4 switches with lens 1,2,3,4 and no reads.
  - Required: pending_cnt=3, switch_fail pulses once on the 4th switch. Draining returns rd_len 1,2,3 in order.
- **Same-cycle release.**
  - Stimulus: fill to cnt=3, then assert switch and rd_done together (wr_len=9).
  - Required: no switch_fail, pending_cnt stays 3, and the last frame after draining has rd_len=9.
- **Abort.**
  - Stimulus: cnt=2, then rd_done_all coincident with switch.
  - Required: pending_cnt=0, unread=0, no switch_fail. The next switch gives cnt=1.
- **Wrap and error flag.**
  - Stimulus: 10 single-frame commit/release cycles, the 7th with wr_err=1.
  - Required: rd_err=1 only for the 7th frame; pointers wrap with no data corruption (per-frame pattern check).
- **Async reset mid-operation.**
  - Stimulus: assert reset_n low at cnt=2 between clock edges.
  - Required: unread, pending_cnt, rd_word and switch_fail are 0 immediately.
